bus_mover: RTL
==============

Name: bus_mover

Overview:
- Execution stage directly downstream of the instruction decoder. Consumes `addr_bus` as {source code, destination code} and `data_bus` as the immediate. Performs one register-to-register move per core_clock.
- Owns the program counter that addresses instruction ROM, eight general registers R0–R7, an output port and a conditional-jump target.
- ROM read data returns to the decoder as `instructor`.

Parameters:
- IR_WIDTH, 8, width of addr_bus and rom_addr; upper nibble is the source code, lower nibble is the destination code.
- DATA_WIDTH, 8, width of data values, registers and ports.
- PC_RESET, 8'h00, program counter value after reset.

Ports:
- core_clock  input  1  core clock; gated by the decoder (held low when paused).
- core_rst_n  input  1  asynchronous active-low reset.
- addr_bus  input  IR_WIDTH  {src[7:4], dst[3:0]} from the decoder.
- data_bus  input  DATA_WIDTH  immediate from the decoder; meaningful only when src==ROM.
- gpio_in  input  DATA_WIDTH  external input port, readable as source IN.
- rom_addr  output  IR_WIDTH  registered program counter; drives the instruction ROM address.
- gpio_out  output  DATA_WIDTH  registered output port.
- r0_zero  output  1  combinational, high when R0==0 (status/debug).

Behaviour:
- Code map (4-bit):
  - NULL=0: source reads 0; as destination, no write.
  - ROM=1: source is data_bus; as destination, ignored.
  - PC=2: source reads the current rom_addr; as destination, unconditional jump.
  - OUT=3: destination only; as source reads gpio_out.
  - IN=4: source only reads gpio_in; as destination, ignored.
  - JZ=5: destination only; jumps if R0==0. As source reads 0.
  - 6–7: reserved; read 0, writes ignored.
  - 8–F: R0–R7, read/write.
- Reset (async, core_rst_n low): rom_addr=PC_RESET, R0–R7=0, gpio_out=0. Takes effect immediately, mid-cycle included. First fetch after release is at PC_RESET.
- Source read: combinational mux on addr_bus[7:4], yielding src_val.
- Destination write: on the core_clock rising edge the addressed destination captures src_val. Zero-cycle read, one-cycle write latency: a value written at edge N is readable by the move presented after edge N.
- Program counter, evaluated every rising edge in priority order:
  1. dst==PC: rom_addr <= src_val.
  2. dst==JZ and R0==0 (pre-edge value): rom_addr <= src_val.
  3. Otherwise: rom_addr <= rom_addr+1, wrapping mod 2^IR_WIDTH (8'hFF -> 8'h00).
  - JZ with R0!=0 increments normally.
- src==dst register: the register rewrites its own value, with no glitch.
- Move R0->JZ: tests the old R0 value. If old R0 is 0, the jump target is 0.
- {NULL,NULL} and {NULL,ROM}: no architectural write; PC increments.
- The decoder presents {NULL,NULL} during its immediate-fetch phase. This block then only increments the PC, which advances past the immediate byte. The following cycle delivers {ROM,dst} with data_bus, and dst is written.
- Stop/pause: the decoder gates core_clock, so state holds with no extra logic here. No other enable exists.
- All outputs except r0_zero are registered. There is no combinational path from addr_bus to rom_addr.

Decomposition:
- Shared define file gains:
  - the code constants NULL, ROM, PC, OUT, IN, JZ, REG_BASE (4'h8);
  - IR_WIDTH and DATA_WIDTH, reused from the existing defines.
- One sub-module: `reg_bank`. It holds the 8×DATA_WIDTH register array with async reset, one combinational read port (3-bit index) and one write port (write enable, 3-bit index, data).
- `bus_mover` holds the source mux, destination decode, PC and gpio_out.

Test Plan:
- Reset then release, addr_bus=8'h01 held for 4 clocks -> rom_addr sequence 00,01,02,03,04; all registers 0.
- addr_bus=8'h18, data_bus=8'h5A, one edge -> R0=5A. Then addr_bus=8'h8F, one edge -> R7=5A. Then 8'hF3 -> gpio_out=5A.
- Assert reset mid-run with R3=0x77 and rom_addr=0x10 -> R3=0 and rom_addr=0 immediately, before the next clock edge.
- With R0=0, addr_bus=8'h15, data_bus=8'h40 -> rom_addr=40. Repeat with R0=1 -> rom_addr increments instead.
- addr_bus=8'h12, data_bus=8'hFF -> rom_addr=FF; next cycle with NULL/ROM -> rom_addr wraps to 00.
- addr_bus=8'h4A with gpio_in=8'hC3 -> R2=C3. addr_bus=8'h2B at rom_addr=0x21 -> R3=21. Writes to codes 1, 4, 6 and 7 -> no state change.

Source files
------------

// File: rtl/bus_mover_pkg.sv
// Shared widths and source/destination codes for the move-execution stage.
package bus_mover_pkg;

    localparam int IR_WIDTH   = 8;
    localparam int DATA_WIDTH = 8;
    localparam int NUM_REGS   = 8;
    localparam int CODE_W     = 4;

    localparam logic [CODE_W-1:0] CODE_NULL = 4'h0;
    localparam logic [CODE_W-1:0] CODE_ROM  = 4'h1;
    localparam logic [CODE_W-1:0] CODE_PC   = 4'h2;
    localparam logic [CODE_W-1:0] CODE_OUT  = 4'h3;
    localparam logic [CODE_W-1:0] CODE_IN   = 4'h4;
    localparam logic [CODE_W-1:0] CODE_JZ   = 4'h5;
    localparam logic [CODE_W-1:0] REG_BASE  = 4'h8;

    // Codes 8-F map onto R0-R7; the top bit alone selects the register file.
    function automatic logic is_reg(input logic [CODE_W-1:0] code);
        return code[CODE_W-1];
    endfunction

endpackage

// File: rtl/bus_mover_if.sv
// Decoder-facing bus: move instruction and immediate in, ROM address out.
interface bus_mover_if;
    import bus_mover_pkg::*;

    logic [IR_WIDTH-1:0]   addr_bus;
    logic [DATA_WIDTH-1:0] data_bus;
    logic [IR_WIDTH-1:0]   rom_addr;

    modport master (output addr_bus, output data_bus, input rom_addr);
    modport slave  (input addr_bus, input data_bus, output rom_addr);

endinterface

// File: rtl/bus_mover_reg_bank.sv
// General register file R0-R7: one combinational read port, one write port.
module reg_bank
    import bus_mover_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  we,
    input  logic [2:0]            wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] r0
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        if (we) regs_d[wr_idx] = wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd_data = regs_q[rd_idx];
    assign r0      = regs_q[0];

endmodule

// File: rtl/bus_mover.sv
// Move-execution stage: source mux, destination decode, program counter and output port.
module bus_mover
    import bus_mover_pkg::*;
#(
    parameter logic [IR_WIDTH-1:0] PC_RESET = 8'h00
) (
    input  logic                  core_clock,
    input  logic                  core_rst_n,
    bus_mover_if.slave            bus,
    input  logic [DATA_WIDTH-1:0] gpio_in,
    output logic [DATA_WIDTH-1:0] gpio_out,
    output logic                  r0_zero
);

    logic [CODE_W-1:0]     src, dst;
    logic [DATA_WIDTH-1:0] src_val;
    logic [DATA_WIDTH-1:0] rd_data, r0;
    logic [IR_WIDTH-1:0]   rom_addr_q, rom_addr_d;
    logic [DATA_WIDTH-1:0] gpio_out_q, gpio_out_d;
    logic                  reg_we;

    assign src = bus.addr_bus[IR_WIDTH-1 -: CODE_W];
    assign dst = bus.addr_bus[CODE_W-1:0];

    reg_bank u_regs (
        .clk     (core_clock),
        .rst_n   (core_rst_n),
        .rd_idx  (src[2:0]),
        .rd_data (rd_data),
        .we      (reg_we),
        .wr_idx  (dst[2:0]),
        .wr_data (src_val),
        .r0      (r0)
    );

    always_comb begin
        src_val = '0;
        case (src)
            CODE_ROM: src_val = bus.data_bus;
            CODE_PC:  src_val = DATA_WIDTH'(rom_addr_q);
            CODE_OUT: src_val = gpio_out_q;
            CODE_IN:  src_val = gpio_in;
            default:  src_val = is_reg(src) ? rd_data : '0;
        endcase
    end

    // JZ tests R0 as it stands before this edge, so R0->JZ sees the old value.
    always_comb begin
        rom_addr_d = rom_addr_q + 1'b1;
        if (dst == CODE_PC || (dst == CODE_JZ && r0 == '0))
            rom_addr_d = IR_WIDTH'(src_val);
        gpio_out_d = (dst == CODE_OUT) ? src_val : gpio_out_q;
        reg_we     = is_reg(dst);
    end

    always_ff @(posedge core_clock or negedge core_rst_n) begin
        if (!core_rst_n) begin
            rom_addr_q <= PC_RESET;
            gpio_out_q <= '0;
        end else begin
            rom_addr_q <= rom_addr_d;
            gpio_out_q <= gpio_out_d;
        end
    end

    assign bus.rom_addr = rom_addr_q;
    assign gpio_out     = gpio_out_q;
    assign r0_zero      = (r0 == '0);

endmodule
